// File: rtl/cpx_rx_deframer_if.sv
// cpx_rx_deframer_if: FIFO-side and core-side signals of the CPX receive deframer.
interface cpx_rx_deframer_if #(
   parameter int WORD_W = 32,
   parameter int CTL_W  = 32,
   parameter int PKT_W  = 145,
   parameter int NUM_CH = 2
);
   logic                    fifo_empty;
   logic                    fifo_read;
   logic [CTL_W+WORD_W-1:0] fifo_data;
   logic [NUM_CH-1:0]       pkt_valid;
   logic [NUM_CH-1:0]       pkt_ready;
   logic [PKT_W-1:0]        pkt_data;
   logic                    err_pulse;
   logic [15:0]             err_count;
   modport master (
      input  fifo_empty, fifo_data, pkt_ready,
      output fifo_read, pkt_valid, pkt_data, err_pulse, err_count
   );
   modport slave (
      output fifo_empty, fifo_data, pkt_ready,
      input  fifo_read, pkt_valid, pkt_data, err_pulse, err_count
   );
endinterface

// File: rtl/cpx_rx_deframer.sv
// cpx_rx_deframer: pops {ctl,data} words, assembles fixed-length packets MSB-first and routes each to one of NUM_CH cores.
// Define CPX_RX_FRAME_CHECK_EN to enable framing-error detection, err_pulse and the saturating err_count.
module cpx_rx_deframer #(
   parameter int WORD_W    = 32,
   parameter int CTL_W     = 32,
   parameter int PKT_WORDS = 8,
   parameter int PKT_W     = 145,
   parameter int NUM_CH    = 2,
   parameter int DEST_LSB  = 112
) (
   input  logic              clk,
   input  logic              rst_n,
   cpx_rx_deframer_if.master bus
);
   localparam int ASM_W = PKT_WORDS * WORD_W;
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int CNT_W = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
   localparam logic [NUM_CH-1:0] ONE = NUM_CH'(1);

   typedef enum logic [1:0] {IDLE, ASM, HOLD} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d, idx;
   logic [ASM_W-1:0]    buf_q, buf_d;
   logic [NUM_CH-1:0]   valid_q, valid_d;
   logic [CH_W-1:0]     dest;
   logic [WORD_W-1:0]   word;
   logic                xfer, pop, wr;

   assign word          = bus.fifo_data[WORD_W-1:0];
   // In HOLD valid_q is one-hot on dest, so this is pkt_ready[dest]
   assign xfer          = (state_q == HOLD) && |(valid_q & bus.pkt_ready);
   assign pop           = !bus.fifo_empty && (state_q != HOLD || xfer);
   assign bus.fifo_read = pop;
   assign bus.pkt_valid = valid_q;
   assign bus.pkt_data  = buf_q[ASM_W-1 -: PKT_W];

`ifdef CPX_RX_FRAME_CHECK_EN
   logic        sop, in_pkt, err_d, err_q;
   logic [15:0] err_cnt_q;
   assign sop           = bus.fifo_data[WORD_W+3];
   assign in_pkt        = bus.fifo_data[WORD_W+4];
   assign bus.err_pulse = err_q;
   assign bus.err_count = err_cnt_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         err_q <= err_d;
         if (err_d && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
      end
`else
   assign bus.err_pulse = 1'b0;
   assign bus.err_count = '0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      buf_d   = buf_q;
      valid_d = valid_q;
      wr      = 1'b0;
      idx     = cnt_q;
`ifdef CPX_RX_FRAME_CHECK_EN
      err_d   = 1'b0;
`endif
      if (xfer) begin
         valid_d = '0;
         state_d = IDLE;
      end
      // A pop in HOLD only happens on the transfer cycle and starts a new packet
      if (pop) begin
         if (state_q != ASM) begin
            idx = '0;
`ifdef CPX_RX_FRAME_CHECK_EN
            wr    = sop;
            err_d = !sop;
`else
            wr    = 1'b1;
`endif
         end else begin
`ifdef CPX_RX_FRAME_CHECK_EN
            if (sop) begin
               idx   = '0;
               wr    = 1'b1;
               err_d = 1'b1;
            end else if (!in_pkt) begin
               err_d   = 1'b1;
               state_d = IDLE;
               cnt_d   = '0;
            end else wr = 1'b1;
`else
            wr = 1'b1;
`endif
         end
      end
      for (int k = 0; k < PKT_WORDS; k++)
         if (wr && idx == CNT_W'(k)) buf_d[ASM_W-1-k*WORD_W -: WORD_W] = word;
      dest = buf_d[ASM_W-PKT_W+DEST_LSB +: CH_W];
      if (wr) begin
         state_d = ASM;
         cnt_d   = idx + 1'b1;
         if (idx == CNT_W'(PKT_WORDS-1)) begin
            cnt_d = '0;
`ifdef CPX_RX_FRAME_CHECK_EN
            state_d = (int'(dest) >= NUM_CH) ? IDLE : HOLD;
            err_d   = int'(dest) >= NUM_CH;
            valid_d = (int'(dest) >= NUM_CH) ? '0 : ONE << dest;
`else
            state_d = HOLD;
            valid_d = (int'(dest) >= NUM_CH) ? ONE << (NUM_CH-1) : ONE << dest;
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         buf_q   <= '0;
         valid_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         buf_q   <= buf_d;
         valid_q <= valid_d;
      end
endmodule

// File: tb/tb_cpx_rx_deframer.sv
// tb_cpx_rx_deframer: randomized and directed bench for cpx_rx_deframer with a stream-level packet model.
// Expectations follow CPX_RX_FRAME_CHECK_EN the same way the design does.
module tb_cpx_rx_deframer;
   localparam int NCH = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   cpx_rx_deframer_if #(.WORD_W(32), .CTL_W(32), .PKT_W(145), .NUM_CH(NCH)) bus ();

   cpx_rx_deframer #(
      .WORD_W(32), .CTL_W(32), .PKT_WORDS(8), .PKT_W(145), .NUM_CH(NCH), .DEST_LSB(112)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   typedef struct {int ch; logic [144:0] data;} pkt_t;

   int checks = 0, errors = 0, cyc = 0;
   logic [63:0] in_q[$];
   pkt_t exp_q[$];
   logic [255:0] m_acc;
   int m_n, m_err, m_emit;
   bit m_in;
   int gap_pct, rdy_mode;
   int pops, first_pop, last_pop, pulses;
   int xfer_cyc[$], rise_cyc[$];
   logic [NCH-1:0] xfer_v[$];
   logic [NCH-1:0] prev_valid;
   logic [144:0] last_d;

   // Packet model: concatenate words MSB-first, keep the top 145 bits, destination at bits 113:112
   task automatic model_emit();
      logic [144:0] p;
      int d;
      p    = m_acc[255:111];
      d    = int'(p[113:112]);
      m_n  = 0;
      m_in = 0;
`ifdef CPX_RX_FRAME_CHECK_EN
      if (d >= NCH) m_err++;
      else begin
         exp_q.push_back('{d, p});
         m_emit++;
      end
`else
      exp_q.push_back('{(d >= NCH) ? NCH - 1 : d, p});
      m_emit++;
`endif
   endtask

   task automatic model_add(input logic [31:0] d);
      m_acc = {m_acc[223:0], d};
      m_n++;
      m_in = 1;
      if (m_n == 8) model_emit();
   endtask

   task automatic model_word(input logic [63:0] w);
`ifdef CPX_RX_FRAME_CHECK_EN
      if (!m_in) begin
         if (w[35]) begin
            m_n = 0;
            model_add(w[31:0]);
         end else m_err++;
      end else if (w[35]) begin
         m_err++;
         m_n = 0;
         model_add(w[31:0]);
      end else if (!w[36]) begin
         m_err++;
         m_n  = 0;
         m_in = 0;
      end else model_add(w[31:0]);
`else
      model_add(w[31:0]);
`endif
   endtask

   task automatic push(input logic [31:0] c, input logic [31:0] d);
      in_q.push_back({c, d});
      model_word({c, d});
   endtask

   // Destination = {word0[0], word1[31]}
   task automatic push_pkt(input int dest, input int nwords);
      logic [31:0] d;
      for (int i = 0; i < nwords; i++) begin
         d = $urandom;
         if (i == 0) d[0] = dest[1];
         if (i == 1) d[31] = dest[0];
         push((i == 0) ? 32'h18 : 32'h10, d);
      end
   endtask

   task automatic clear_logs();
      pops = 0;
      pulses = 0;
      xfer_cyc.delete();
      rise_cyc.delete();
      xfer_v.delete();
      prev_valid = '0;
   endtask

   task automatic step();
      logic [NCH-1:0] ev;
      pkt_t e;
      @(negedge clk);
      bus.fifo_empty = (in_q.size() == 0) || ($urandom_range(99) < gap_pct);
      bus.fifo_data  = (in_q.size() != 0) ? in_q[0] : 64'h0;
      bus.pkt_ready  = (rdy_mode == 0) ? '0 : (rdy_mode == 1) ? '1 : NCH'($urandom_range(7));
      #1;
      if (bus.fifo_read) begin
         checks++;
         if (bus.fifo_empty) begin
            errors++;
            $display("FAIL read_when_empty fifo_read=1 required=0 cyc=%0d", cyc);
         end else begin
            void'(in_q.pop_front());
            if (pops == 0) first_pop = cyc;
            last_pop = cyc;
            pops++;
         end
      end
      if (bus.pkt_valid != 0 && prev_valid == 0) rise_cyc.push_back(cyc);
      prev_valid = bus.pkt_valid;
      if (bus.err_pulse) pulses++;
      if (|(bus.pkt_valid & bus.pkt_ready)) begin
         checks++;
         xfer_cyc.push_back(cyc);
         xfer_v.push_back(bus.pkt_valid);
         last_d = bus.pkt_data;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL xfer_unexpected valid=%b data=%h required=no transfer", bus.pkt_valid, bus.pkt_data);
         end else begin
            e  = exp_q.pop_front();
            ev = NCH'(1) << e.ch;
            if (bus.pkt_valid !== ev || bus.pkt_data !== e.data) begin
               errors++;
               $display("FAIL xfer valid=%b data=%h required valid=%b data=%h", bus.pkt_valid, bus.pkt_data, ev, e.data);
            end
         end
      end
      cyc++;
   endtask

   task automatic drain(input int max);
      int n = 0;
      while ((in_q.size() != 0 || exp_q.size() != 0 || bus.pkt_valid != 0) && n < max) begin
         step();
         n++;
      end
      checks++;
      if (n >= max) begin
         errors++;
         $display("FAIL drain_timeout pending_words=%0d pending_pkts=%0d required 0 within %0d cycles", in_q.size(), exp_q.size(), max);
      end
      repeat (2) step();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.fifo_empty = 1'b1;
      bus.pkt_ready  = '0;
      in_q.delete();
      exp_q.delete();
      m_acc = '0;
      m_n = 0;
      m_in = 0;
      m_err = 0;
      m_emit = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      clear_logs();
   endtask

   task automatic test_reset();
      bus.fifo_empty = 1'b1;
      bus.fifo_data  = '0;
      bus.pkt_ready  = '0;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (bus.pkt_valid !== '0 || bus.pkt_data !== '0 || bus.err_pulse !== 1'b0 || bus.err_count !== 16'h0) begin
         errors++;
         $display("FAIL reset_outputs valid=%b data=%h pulse=%b count=%h required all zero", bus.pkt_valid, bus.pkt_data, bus.err_pulse, bus.err_count);
      end
      checks++;
      if (bus.fifo_read !== 1'b0) begin
         errors++;
         $display("FAIL reset_read_empty fifo_read=%b required=0", bus.fifo_read);
      end
      bus.fifo_empty = 1'b0;
      #1;
      checks++;
      if (bus.fifo_read !== 1'b1) begin
         errors++;
         $display("FAIL reset_read_idle fifo_read=%b required=1", bus.fifo_read);
      end
      bus.fifo_empty = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      do_reset();
      gap_pct = 0;
      rdy_mode = 1;
      push(32'h18, 32'h00017000);
      for (int i = 1; i < 8; i++) begin
`ifdef CPX_RX_FRAME_CHECK_EN
         push(32'h10, $urandom & 32'h7FFF_FFFF);
`else
         push((i < 5) ? 32'h10 : 32'h0, $urandom & 32'h7FFF_FFFF);
`endif
      end
      drain(100);
      checks++;
      if (xfer_v.size() != 1 || xfer_v[0] !== 3'b001) begin
         errors++;
         $display("FAIL basic_route transfers=%0d first_valid=%b required 1 transfer valid=001", xfer_v.size(), (xfer_v.size() != 0) ? xfer_v[0] : 3'b0);
      end
      checks++;
      if (rise_cyc.size() == 0 || rise_cyc[0] != last_pop + 1) begin
         errors++;
         $display("FAIL basic_latency valid_cycle=%0d required=%0d", (rise_cyc.size() != 0) ? rise_cyc[0] : -1, last_pop + 1);
      end
      checks++;
      if (last_d[144:113] !== 32'h00017000) begin
         errors++;
         $display("FAIL basic_word0 data=%h required=00017000", last_d[144:113]);
      end
      checks++;
      if (bus.err_count !== 16'h0) begin
         errors++;
         $display("FAIL basic_err_count got=%0d required=0", bus.err_count);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      gap_pct = 0;
      rdy_mode = 1;
      push_pkt(1, 8);
      push_pkt(0, 8);
      drain(100);
      checks++;
      if (pops != 16 || last_pop - first_pop != 15) begin
         errors++;
         $display("FAIL b2b_reads pops=%0d span=%0d required pops=16 span=15", pops, last_pop - first_pop);
      end
      checks++;
      if (xfer_v.size() != 2 || xfer_v[0] !== 3'b010 || xfer_v[1] !== 3'b001 || xfer_cyc[1] - xfer_cyc[0] != 8) begin
         errors++;
         $display("FAIL b2b_xfers count=%0d gap=%0d required count=2 valid 010,001 gap=8", xfer_v.size(), (xfer_cyc.size() == 2) ? xfer_cyc[1] - xfer_cyc[0] : -1);
      end
   endtask

   task automatic test_backpressure();
      logic [144:0] d0;
      logic [NCH-1:0] v0;
      int n = 0, bad = 0;
      do_reset();
      gap_pct = 0;
      rdy_mode = 0;
      push_pkt(2, 8);
      push_pkt(0, 8);
      while (bus.pkt_valid == 0 && n < 50) begin
         step();
         n++;
      end
      checks++;
      if (n >= 50) begin
         errors++;
         $display("FAIL bp_valid_timeout valid=%b required nonzero within 50 cycles", bus.pkt_valid);
      end
      d0 = bus.pkt_data;
      v0 = bus.pkt_valid;
      for (int i = 0; i < 20; i++) begin
         step();
         if (bus.fifo_read !== 1'b0 || bus.pkt_data !== d0 || bus.pkt_valid !== v0) bad++;
      end
      checks++;
      if (bad != 0 || v0 !== 3'b100) begin
         errors++;
         $display("FAIL bp_hold violations=%0d valid=%b required violations=0 valid=100", bad, v0);
      end
      rdy_mode = 1;
      step();
      checks++;
      if (xfer_cyc.size() != 1 || xfer_cyc[0] != cyc - 1 || bus.fifo_read !== 1'b1) begin
         errors++;
         $display("FAIL bp_release transfers=%0d fifo_read=%b required 1 transfer with fifo_read=1", xfer_cyc.size(), bus.fifo_read);
      end
      drain(100);
   endtask

   task automatic test_sop_mid();
      do_reset();
      gap_pct = 30;
      rdy_mode = 2;
      push_pkt(1, 3);
      push_pkt(1, 8);
      drain(300);
      checks++;
      if (bus.err_count !== 16'(m_err) || pulses != m_err) begin
         errors++;
         $display("FAIL sop_mid_errors count=%0d pulses=%0d required=%0d", bus.err_count, pulses, m_err);
      end
      checks++;
      if (xfer_v.size() != m_emit) begin
         errors++;
         $display("FAIL sop_mid_packets got=%0d required=%0d", xfer_v.size(), m_emit);
      end
   endtask

   task automatic test_stray_dest();
      do_reset();
      gap_pct = 20;
      rdy_mode = 1;
      push(32'h10, $urandom);
      push_pkt(3, 8);
      push_pkt(2, 8);
      drain(300);
      checks++;
      if (bus.err_count !== 16'(m_err) || pulses != m_err) begin
         errors++;
         $display("FAIL stray_dest_errors count=%0d pulses=%0d required=%0d", bus.err_count, pulses, m_err);
      end
      checks++;
      if (xfer_v.size() != m_emit) begin
         errors++;
         $display("FAIL stray_dest_packets got=%0d required=%0d", xfer_v.size(), m_emit);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      gap_pct = 0;
      rdy_mode = 1;
      push_pkt(1, 8);
      repeat (5) step();
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (bus.pkt_valid !== '0 || bus.pkt_data !== '0 || bus.err_pulse !== 1'b0 || bus.err_count !== 16'h0) begin
         errors++;
         $display("FAIL reset_mid_outputs valid=%b data=%h pulse=%b count=%h required all zero", bus.pkt_valid, bus.pkt_data, bus.err_pulse, bus.err_count);
      end
      checks++;
      if (bus.fifo_read !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_read fifo_read=%b required=1", bus.fifo_read);
      end
      in_q.delete();
      exp_q.delete();
      m_n = 0;
      m_in = 0;
      m_emit = 0;
      @(negedge clk);
      bus.fifo_empty = 1'b1;
      rst_n = 1'b1;
      clear_logs();
      push_pkt(1, 8);
      drain(100);
      checks++;
      if (xfer_v.size() != 1 || xfer_v[0] !== 3'b010) begin
         errors++;
         $display("FAIL reset_mid_recover transfers=%0d required 1 on channel 1", xfer_v.size());
      end
   endtask

   task automatic test_random();
      int r, k;
      do_reset();
      gap_pct = 25;
      rdy_mode = 2;
      for (int p = 0; p < 40; p++) begin
         r = $urandom_range(9);
         k = $urandom_range(1, 7);
         if (r == 0) push($urandom & 32'hFFFF_FFF7, $urandom);
         if (r == 1) push_pkt($urandom_range(3), k);
         else if (r == 2) begin
            push_pkt($urandom_range(3), k);
            push(32'h0, $urandom);
         end else push_pkt($urandom_range(3), 8);
      end
      drain(5000);
      checks++;
      if (bus.err_count !== 16'(m_err) || pulses != m_err) begin
         errors++;
         $display("FAIL random_errors count=%0d pulses=%0d required=%0d", bus.err_count, pulses, m_err);
      end
      checks++;
      if (xfer_v.size() != m_emit) begin
         errors++;
         $display("FAIL random_packets got=%0d required=%0d", xfer_v.size(), m_emit);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_backpressure();
      test_sop_mid();
      test_stray_dest();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
